// File: rtl/approx_err_monitor.sv
// approx_err_monitor
//   Measures the accuracy of an approximate adder over a window of
//   N = 2**LOG2_N accepted samples. For each sample, the exact sum in1+in2 is
//   computed. Its absolute distance from approx_out is then accumulated through
//   a two-stage pipeline. At the end of the window the block reports:
//     - the mean absolute error, as a truncating divide by N;
//     - the worst-case absolute error;
//     - the number of samples that had a nonzero error.
//
// Ports
//   clk, rst_n         : rising-edge clock, synchronous active-low reset
//   start              : begin a window (only honoured in IDLE)
//   in_valid, in_ready : sample handshake; a sample is taken when both are 1
//   in1, in2           : operands fed to the approximate adder (WIDTH bits)
//   approx_out         : approximate adder result (WIDTH+1 bits)
//   busy               : window running or draining
//   done               : one-cycle pulse, results valid and updated
//   mae, max_err       : mean / max absolute error of the last window
//   err_count          : samples with nonzero error in the last window
module approx_err_monitor #(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [WIDTH:0]    approx_out,
  output logic              busy,
  output logic              done,
  output logic [WIDTH:0]    mae,
  output logic [WIDTH:0]    max_err,
  output logic [LOG2_N:0]   err_count
);

  localparam int EW = WIDTH + 1;           // error / sum width
  localparam int AW = WIDTH + 1 + LOG2_N;  // N errors of EW bits cannot overflow
  localparam int N  = 1 << LOG2_N;
  localparam logic [LOG2_N:0] LAST = (LOG2_N+1)'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [LOG2_N:0]  n_acc;      // samples accepted in this window
  logic             drain_cnt;  // DRAIN spans exactly two cycles
  logic             s1_vld;
  logic [EW-1:0]    s1_err;
  logic [AW-1:0]    acc;
  logic [EW-1:0]    max_r;
  logic [LOG2_N:0]  nz_cnt;

  logic             accept;
  logic [EW-1:0]    exact;
  logic [EW-1:0]    abs_err;

  // n_acc never reaches N while in RUN because the Nth accept leaves RUN.
  // The MSB term still keeps in_ready low if that assumption is ever broken.
  assign in_ready = (state == RUN) && !n_acc[LOG2_N];
  assign busy     = (state == RUN) || (state == DRAIN);
  assign accept   = in_valid && in_ready;

  // The exact sum carries into bit WIDTH, so the error never truncates.
  always_comb begin
    exact   = {1'b0, in1} + {1'b0, in2};
    abs_err = (exact >= approx_out) ? (exact - approx_out) : (approx_out - exact);
  end

  // Stage 1: register the per-sample absolute error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_err <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_err <= abs_err;
    end
  end

  // Control FSM plus stage 2 (accumulate / max / nonzero count).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_acc     <= '0;
      drain_cnt <= 1'b0;
      acc       <= '0;
      max_r     <= '0;
      nz_cnt    <= '0;
      done      <= 1'b0;
      mae       <= '0;
      max_err   <= '0;
      err_count <= '0;
    end else begin
      done <= 1'b0;

      if (s1_vld) begin
        acc <= acc + AW'(s1_err);
        if (s1_err > max_r) max_r <= s1_err;
        if (|s1_err) nz_cnt <= nz_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          // The pipeline is empty in IDLE, so clearing here cannot race stage 2.
          if (start) begin
            state  <= RUN;
            n_acc  <= '0;
            acc    <= '0;
            max_r  <= '0;
            nz_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            n_acc <= n_acc + 1'b1;
            if (n_acc == LAST) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Cycle 1: the last sample moves from stage 1 into acc.
          // Cycle 2: acc is final, so publish the results.
          if (drain_cnt) begin
            state     <= DONE;
            done      <= 1'b1;
            mae       <= acc[LOG2_N +: EW];
            max_err   <= max_r;
            err_count <= nz_cnt;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width.
REQ-002 SHALL have parameter LOG2_N, default 8, log2 of window length N (N = 2^LOG2_N samples).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset (synchronous, active-low).
REQ-005 SHALL have port start, input, 1, begin a measurement window.
REQ-006 SHALL have port in_valid, input, 1, sample presented.
REQ-007 SHALL have port in_ready, output, 1, monitor accepts a sample.
REQ-008 SHALL have port in1, input, WIDTH, operand A as applied to the approximate adder.
REQ-009 SHALL have port in2, input, WIDTH, operand B as applied to the approximate adder.
REQ-010 SHALL have port approx_out, input, WIDTH+1, approximate adder result for in1/in2.
REQ-011 SHALL have port busy, output, 1, window in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when results are valid.
REQ-013 SHALL have port mae, output, WIDTH+1, mean absolute error of the last window.
REQ-014 SHALL have port max_err, output, WIDTH+1, worst-case absolute error of the last window.
REQ-015 SHALL have port err_count, output, LOG2_N+1, number of samples with nonzero error.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE -> RUN on start=1; accumulator, max, counts cleared in that same cycle; start ignored in RUN, DRAIN, DONE.
REQ-018 SHALL drive in_ready=1 only in RUN while accepted count < N.
REQ-019 SHALL accept a sample exactly on cycles with in_valid=1 and in_ready=1; in_valid without in_ready is ignored.
REQ-020 Stage 1 (registered): exact = in1 + in2 at WIDTH+1 bits, no overflow loss; abs_err = |exact - approx_out| at WIDTH+1 bits.
REQ-021 Stage 2 (registered): acc += abs_err (width WIDTH+1+LOG2_N, cannot overflow); max = max(max, abs_err); err_count += (abs_err != 0).
REQ-022 RUN -> DRAIN on the cycle the Nth sample is accepted; DRAIN lasts exactly 2 cycles until both stages are empty.
REQ-023 DRAIN -> DONE; in DONE: done=1 for exactly one cycle, mae = acc >> LOG2_N (truncating), max_err, err_count updated; then DONE -> IDLE.
REQ-024 Latency: done asserts 3 cycles after the cycle accepting the Nth sample.
REQ-025 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-026 mae, max_err, err_count SHALL hold their values from DONE until the next DONE; not altered by a new start.
REQ-027 err_count reaching N (all samples erroneous) SHALL be representable without wrap.
REQ-028 Samples with in_valid gaps SHALL be tolerated; window completes only after N accepted samples.

Reset
REQ-029 On rst_n=0 at a rising clk edge: state IDLE, in_ready=0, busy=0, done=0, mae=0, max_err=0, err_count=0, accumulators and pipeline valids cleared.
REQ-030 Reset asserted mid-window SHALL discard the window; no done pulse is produced for it.

Verification
REQ-031 LOG2_N=2, approx_out = exact for 4 samples -> done with mae=0, max_err=0, err_count=0.
REQ-032 LOG2_N=2, 4 samples in1=0, in2=0, approx_out=17'h00400 -> mae=1024, max_err=1024, err_count=4.
REQ-033 LOG2_N=2, errors 1, 2, 3, 5 -> mae=2 (11>>2), max_err=5, err_count=4, done exactly 3 cycles after 4th accept.
REQ-034 in1=16'hFFFF, in2=16'hFFFF, approx_out=17'h1FFFE -> err 0; approx_out=0 -> err 131070, no truncation.
REQ-035 rst_n=0 after 2 of 4 samples, then start plus 4 samples of err 8 -> single done, mae=8, no stale contribution.
REQ-036 start pulsed during RUN and in_valid held with in_ready=0 in DRAIN -> no restart, no extra sample counted.
